// File: rtl/addecrc.sv
// Nibble-stream framer: pads short frames with zero nibbles up to MINLEN and
// appends a reflected CRC-32 FCS, or passes the stream through registered when disabled.
module addecrc #(
    parameter int MINLEN = 120
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_ce,
    input  logic       i_en,
    input  logic       i_cancel,
    input  logic       i_v,
    input  logic [3:0] i_nibble,
    output logic       o_v,
    output logic [3:0] o_nibble,
    output logic       o_busy
);

    typedef enum logic [1:0] {IDLE, DATA, PAD, FCS} state_t;

    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;
    localparam logic [15:0] MIN_W    = MINLEN[15:0];

    state_t      state_q, state_d;
    logic [31:0] crc_q, crc_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  fcsIdx_q, fcsIdx_d;
    logic        armed_q, armed_d;
    logic        outValid_q, outValid_d;
    logic [3:0]  outNibble_q, outNibble_d;

    logic        padNeeded;
    logic [15:0] cntInc;

    // Four LSB-first shift steps of the reflected CRC for one nibble.
    function automatic logic [31:0] crcNibble(input logic [31:0] crc, input logic [3:0] nib);
        logic [31:0] c;
        c = crc ^ {28'd0, nib};
        for (int i = 0; i < 4; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    assign padNeeded = (cnt_q < MIN_W);
    assign cntInc    = padNeeded ? cnt_q + 16'd1 : cnt_q;

    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        cnt_d       = cnt_q;
        fcsIdx_d    = fcsIdx_q;
        armed_d     = armed_q;
        outValid_d  = outValid_q;
        outNibble_d = outNibble_q;

        if (i_ce) begin
            armed_d     = ~i_v;
            outValid_d  = 1'b0;
            outNibble_d = 4'h0;
            if (i_cancel) begin
                state_d  = IDLE;
                crc_d    = CRC_INIT;
                cnt_d    = 16'd0;
                fcsIdx_d = 3'd0;
                armed_d  = 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        crc_d    = CRC_INIT;
                        cnt_d    = 16'd0;
                        fcsIdx_d = 3'd0;
                        if (!i_en) begin
                            outValid_d  = i_v;
                            outNibble_d = i_nibble;
                        end else if (armed_q && i_v) begin
                            outValid_d  = 1'b1;
                            outNibble_d = i_nibble;
                            crc_d       = crcNibble(CRC_INIT, i_nibble);
                            cnt_d       = (MIN_W != 16'd0) ? 16'd1 : 16'd0;
                            state_d     = DATA;
                        end
                    end
                    DATA, PAD: begin
                        outValid_d = 1'b1;
                        if (state_q == DATA && i_v) begin
                            outNibble_d = i_nibble;
                            crc_d       = crcNibble(crc_q, i_nibble);
                            cnt_d       = cntInc;
                        end else if (padNeeded) begin
                            outNibble_d = 4'h0;
                            crc_d       = crcNibble(crc_q, 4'h0);
                            cnt_d       = cntInc;
                            state_d     = PAD;
                        end else begin
                            // First FCS nibble leaves on the same cycle the frame body ends.
                            outNibble_d = ~crc_q[3:0];
                            crc_d       = crc_q >> 4;
                            fcsIdx_d    = 3'd1;
                            state_d     = FCS;
                        end
                    end
                    FCS: begin
                        outValid_d  = 1'b1;
                        outNibble_d = ~crc_q[3:0];
                        crc_d       = crc_q >> 4;
                        fcsIdx_d    = fcsIdx_q + 3'd1;
                        if (fcsIdx_q == 3'd7) begin
                            state_d = IDLE;
                            cnt_d   = 16'd0;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q     <= IDLE;
            crc_q       <= CRC_INIT;
            cnt_q       <= 16'd0;
            fcsIdx_q    <= 3'd0;
            armed_q     <= 1'b0;
            outValid_q  <= 1'b0;
            outNibble_q <= 4'h0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            cnt_q       <= cnt_d;
            fcsIdx_q    <= fcsIdx_d;
            armed_q     <= armed_d;
            outValid_q  <= outValid_d;
            outNibble_q <= outNibble_d;
        end
    end

    assign o_v      = outValid_q;
    assign o_nibble = outNibble_q;
    assign o_busy   = (state_q != IDLE);

endmodule
